// File: rtl/requant_seq_ctrl.sv
// requant_seq_ctrl
//   Sequences one accumulator vector at a time through an external requantizer.
//   Each accepted vector is issued with its M/exp table address (which wraps at
//   cfg_num_groups). The requantizer result is held on the output stream until
//   it is consumed. A requantizer that never answers is timed out: the vector
//   is dropped and a sticky error is raised.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cfg_start             one-cycle pulse that starts a layer (honoured in IDLE only)
//   cfg_num_groups        number of M/exp entries; rq_addr wraps at this value
//   cfg_num_vec           number of vectors in the layer
//   cfg_out_zp            signed output zero-point, forwarded on rq_out_zp
//   abort                 synchronous abort back to IDLE, highest priority
//   s_valid/s_ready/s_acc accumulator input stream
//   rq_start/rq_addr/rq_acc/rq_out_zp   requantizer command
//   rq_ready/rq_done/rq_ofm             requantizer status and result
//   m_valid/m_ready/m_data              output stream
//   busy, layer_done (pulse), err_timeout (sticky)
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no layer active; waiting for cfg_start
// WAIT_IN   | waiting for an accumulator beat (needs rq_ready)
// ISSUE     | one-cycle rq_start; loads the done-timeout timer
// WAIT_DONE | waiting for rq_done, counting down the timeout
// HOLD_OUT  | result held on m_data until m_ready
module requant_seq_ctrl #(
  parameter int LANES   = 16,
  parameter int AW      = 20,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [AW-1:0]         cfg_num_groups,
  input  logic [31:0]           cfg_num_vec,
  input  logic [7:0]            cfg_out_zp,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*32-1:0]   s_acc,
  output logic                  rq_start,
  output logic [AW-1:0]         rq_addr,
  output logic [LANES*32-1:0]   rq_acc,
  output logic [7:0]            rq_out_zp,
  input  logic                  rq_ready,
  input  logic                  rq_done,
  input  logic [LANES*8-1:0]    rq_ofm,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*8-1:0]    m_data,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IN, S_ISSUE, S_WAIT_DONE, S_HOLD_OUT
  } state_t;

  state_t               r_state;
  logic [AW-1:0]        r_num_groups;
  logic [31:0]          r_num_vec;
  logic [31:0]          r_vec_cnt;
  logic [AW-1:0]        r_addr;
  logic [LANES*32-1:0]  r_acc;
  logic [7:0]           r_out_zp;
  logic [LANES*8-1:0]   r_m_data;
  logic                 r_m_valid;
  logic                 r_rq_start;
  logic                 r_busy;
  logic                 r_layer_done;
  logic                 r_err_timeout;
  logic [TW-1:0]        r_timer;

  logic                 w_s_ready;
  logic                 w_timeout;
  logic                 w_advance;
  logic [AW-1:0]        w_addr_inc;
  logic [AW-1:0]        w_addr_next;
  logic [31:0]          w_cnt_next;
  logic                 w_last;

  assign w_s_ready   = (r_state == S_WAIT_IN) & rq_ready;
  assign w_timeout   = (r_state == S_WAIT_DONE) & ~rq_done & (r_timer == '0);
  // A vector retires either by being consumed downstream or by timing out.
  assign w_advance   = w_timeout | ((r_state == S_HOLD_OUT) & m_ready);
  assign w_addr_inc  = r_addr + AW'(1);
  assign w_addr_next = (w_addr_inc == r_num_groups) ? '0 : w_addr_inc;
  assign w_cnt_next  = r_vec_cnt + 32'd1;
  assign w_last      = (w_cnt_next == r_num_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_num_groups  <= '0;
      r_num_vec     <= '0;
      r_vec_cnt     <= '0;
      r_addr        <= '0;
      r_acc         <= '0;
      r_out_zp      <= '0;
      r_m_data      <= '0;
      r_m_valid     <= 1'b0;
      r_rq_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_layer_done  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_timer       <= '0;
    end else begin
      r_layer_done <= 1'b0;
      r_rq_start   <= 1'b0;
      if (abort) begin
        r_state   <= S_IDLE;
        r_m_valid <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cfg_start) begin
              if ((cfg_num_vec != 32'd0) && (cfg_num_groups != '0)) begin
                r_num_groups  <= cfg_num_groups;
                r_num_vec     <= cfg_num_vec;
                r_out_zp      <= cfg_out_zp;
                r_vec_cnt     <= '0;
                r_addr        <= '0;
                r_err_timeout <= 1'b0;
                r_busy        <= 1'b1;
                r_state       <= S_WAIT_IN;
              end else begin
                // Empty layer: report completion without ever going busy.
                r_layer_done <= 1'b1;
              end
            end
          end
          S_WAIT_IN: begin
            if (s_valid && w_s_ready) begin
              r_acc      <= s_acc;
              r_rq_start <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            // Timer reaches zero on the TIMEOUT-th cycle spent in WAIT_DONE.
            r_timer <= TW'(TIMEOUT - 1);
            r_state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (rq_done) begin
              r_m_data  <= rq_ofm;
              r_m_valid <= 1'b1;
              r_state   <= S_HOLD_OUT;
            end else if (r_timer == '0) begin
              r_err_timeout <= 1'b1;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          S_HOLD_OUT: begin
            if (m_ready) r_m_valid <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase

        if (w_advance) begin
          r_vec_cnt <= w_cnt_next;
          r_addr    <= w_addr_next;
          if (w_last) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b1;
          end else begin
            r_state <= S_WAIT_IN;
          end
        end
      end
    end
  end

  assign s_ready     = w_s_ready;
  assign rq_start    = r_rq_start;
  assign rq_addr     = r_addr;
  assign rq_acc      = r_acc;
  assign rq_out_zp   = r_out_zp;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign busy        = r_busy;
  assign layer_done  = r_layer_done;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_requant_seq_ctrl.sv
module tb_requant_seq_ctrl;
  localparam int LANES   = 16;
  localparam int AW      = 20;
  localparam int TIMEOUT = 32;
  localparam int LAT     = 4;

  logic                 clk, rst_n, cfg_start, abort;
  logic [AW-1:0]        cfg_num_groups;
  logic [31:0]          cfg_num_vec;
  logic [7:0]           cfg_out_zp;
  logic                 s_valid, s_ready;
  logic [LANES*32-1:0]  s_acc;
  logic                 rq_start;
  logic [AW-1:0]        rq_addr;
  logic [LANES*32-1:0]  rq_acc;
  logic [7:0]           rq_out_zp;
  logic                 rq_ready, rq_done;
  logic [LANES*8-1:0]   rq_ofm;
  logic                 m_valid, m_ready;
  logic [LANES*8-1:0]   m_data;
  logic                 busy, layer_done, err_timeout;

  requant_seq_ctrl #(.LANES(LANES), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_num_groups(cfg_num_groups), .cfg_num_vec(cfg_num_vec),
    .cfg_out_zp(cfg_out_zp), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_acc(s_acc),
    .rq_start(rq_start), .rq_addr(rq_addr), .rq_acc(rq_acc),
    .rq_out_zp(rq_out_zp), .rq_ready(rq_ready), .rq_done(rq_done),
    .rq_ofm(rq_ofm), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .layer_done(layer_done), .err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [7:0] ZP = 8'hF3;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES*32-1:0] acc_pat(input int k);
    logic [LANES*32-1:0] v;
    for (int j = 0; j < LANES; j++) v[j*32 +: 32] = {8'hA5, 8'h3C, 8'h00, 8'(k*17 + j)};
    return v;
  endfunction

  function automatic logic [LANES*8-1:0] exp_data(input int k);
    logic [LANES*8-1:0] v;
    for (int j = 0; j < LANES; j++) v[j*8 +: 8] = 8'(k*17 + j) + ZP;
    return v;
  endfunction

  // Requantizer model: answers LAT cycles after rq_start unless told to drop.
  int rsp_pend = 0;
  int start_cnt = 0;
  int drop_idx = -1;
  int start_cyc [16];
  logic [AW-1:0] addr_log [16];
  initial begin
    rq_done = 1'b0;
    rq_ofm  = '0;
    forever begin
      @(posedge clk); #1;
      rq_done = 1'b0;
      if (!busy) rsp_pend = 0;
      else if (rsp_pend > 0) begin
        rsp_pend--;
        if (rsp_pend == 0) begin
          rq_done = 1'b1;
          for (int j = 0; j < LANES; j++) rq_ofm[j*8 +: 8] = rq_acc[j*32 +: 8] + rq_out_zp;
        end
      end
      if (rq_start) begin
        if (start_cnt < 16) begin
          addr_log[start_cnt]  = rq_addr;
          start_cyc[start_cnt] = cyc;
        end
        if (start_cnt != drop_idx) rsp_pend = LAT;
        start_cnt++;
      end
    end
  end

  // Output / status monitor.
  int beat_cnt = 0, ld_cnt = 0, busy_cyc = 0, ld_at_beat = -1;
  logic [LANES*8-1:0] beat_log [16];
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (beat_cnt < 16) beat_log[beat_cnt] = m_data;
        beat_cnt++;
      end
      if (layer_done) begin
        ld_cnt++;
        ld_at_beat = beat_cnt;
      end
      if (busy) busy_cyc++;
    end
  end

  // Input feeder: offers vectors feed_idx .. feed_cnt-1 in order.
  int feed_idx = 0, feed_cnt = 0;
  bit feed_acc;
  initial begin
    s_valid = 1'b0;
    s_acc   = '0;
    forever begin
      @(negedge clk);
      feed_acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (feed_acc) feed_idx++;
      if (feed_idx < feed_cnt) begin
        s_valid = 1'b1;
        s_acc   = acc_pat(feed_idx);
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic clr_logs();
    beat_cnt = 0; ld_cnt = 0; ld_at_beat = -1;
    start_cnt = 0; feed_idx = 0;
  endtask

  task automatic start_layer(input logic [AW-1:0] g, input logic [31:0] n);
    cfg_num_groups = g;
    cfg_num_vec    = n;
    cfg_start      = 1'b1;
    step();
    cfg_start      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    chk(tag, 128'(busy), 128'(0));
    step();
  endtask

  task automatic wait_starts(input string tag, input int cnt, input int budget);
    int n = 0;
    while (start_cnt < cnt && n < budget) begin step(); n++; end
    chk(tag, 128'(start_cnt >= cnt), 128'(1));
  endtask

  task automatic wait_mvalid(input string tag, input int budget);
    int n = 0;
    while (!m_valid && n < budget) begin step(); n++; end
    chk(tag, 128'(m_valid), 128'(1));
  endtask

  logic [LANES*8-1:0] d0;
  int s0, b0, err_cyc, n;

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; abort = 1'b0;
    cfg_num_groups = '0; cfg_num_vec = '0; cfg_out_zp = ZP;
    rq_ready = 1'b1; m_ready = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_busy",    128'(busy),        128'(0));
    chk("rst_m_valid", 128'(m_valid),     128'(0));
    chk("rst_s_ready", 128'(s_ready),     128'(0));
    chk("rst_rq_addr", 128'(rq_addr),     128'(0));
    chk("rst_m_data",  128'(m_data),      128'(0));
    chk("rst_err",     128'(err_timeout), 128'(0));
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_busy", 128'(busy), 128'(0));

    // Normal layer, groups=3 vec=7, first output held 10 cycles
    clr_logs(); drop_idx = -1; m_ready = 1'b0; feed_cnt = 7;
    start_layer(3, 7);
    chk("t1_busy", 128'(busy), 128'(1));
    wait_mvalid("t1_mvalid_arrive", 60);
    d0 = m_data;
    chk("t1_beat0_data", 128'(m_data), 128'(exp_data(0)));
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_hold_mvalid", 128'(m_valid), 128'(1));
      chk("t1_hold_mdata",  128'(m_data),  128'(d0));
      chk("t1_hold_sready", 128'(s_ready), 128'(0));
    end
    chk("t1_hold_no_rqstart", 128'(start_cnt), 128'(s0));
    m_ready = 1'b1;
    wait_idle("t1_idle_timeout", 300);
    chk("t1_beats", 128'(beat_cnt), 128'(7));
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t1_beat%0d_data", i), 128'(beat_log[i]), 128'(exp_data(i)));
      chk($sformatf("t1_addr%0d", i),      128'(addr_log[i]), 128'(i % 3));
    end
    chk("t1_layer_done_cnt", 128'(ld_cnt),     128'(1));
    chk("t1_layer_done_pos", 128'(ld_at_beat), 128'(7));
    chk("t1_issue_interval", 128'(start_cyc[6] - start_cyc[5]), 128'(LAT + 3));
    chk("t1_err", 128'(err_timeout), 128'(0));

    // Timeout on the third vector
    clr_logs(); drop_idx = 2; feed_cnt = 7;
    start_layer(3, 7);
    n = 0;
    while (!err_timeout && n < 400) begin step(); n++; end
    chk("t2_err_set", 128'(err_timeout), 128'(1));
    err_cyc = cyc;
    chk("t2_timeout_cycles", 128'(err_cyc - start_cyc[2]), 128'(TIMEOUT + 1));
    chk("t2_no_beat_for_drop", 128'(beat_cnt), 128'(2));
    wait_idle("t2_idle_timeout", 400);
    chk("t2_beats",      128'(beat_cnt),    128'(6));
    chk("t2_beat2_data", 128'(beat_log[2]), 128'(exp_data(3)));
    chk("t2_beat5_data", 128'(beat_log[5]), 128'(exp_data(6)));
    chk("t2_starts",     128'(start_cnt),   128'(7));
    chk("t2_addr2",      128'(addr_log[2]), 128'(2));
    chk("t2_addr3",      128'(addr_log[3]), 128'(0));
    chk("t2_layer_done", 128'(ld_cnt),      128'(1));
    chk("t2_err_sticky", 128'(err_timeout), 128'(1));
    drop_idx = -1;

    // Empty layer starts
    clr_logs(); feed_cnt = 0; b0 = busy_cyc;
    cfg_num_groups = 3; cfg_num_vec = 0; cfg_start = 1'b1;
    step(); cfg_start = 1'b0;
    chk("t3_vec0_done", 128'(layer_done), 128'(1));
    step();
    chk("t3_vec0_done_pulse", 128'(layer_done), 128'(0));
    cfg_num_groups = 0; cfg_num_vec = 5; cfg_start = 1'b1;
    step(); cfg_start = 1'b0;
    chk("t3_grp0_done", 128'(layer_done), 128'(1));
    step();
    chk("t3_never_busy",    128'(busy_cyc),  128'(b0));
    chk("t3_never_rqstart", 128'(start_cnt), 128'(0));

    // Abort while the fourth vector is held on the output
    clr_logs(); m_ready = 1'b1; feed_cnt = 7;
    start_layer(3, 7);
    chk("t4_err_cleared", 128'(err_timeout), 128'(0));
    wait_starts("t4_reach_vec4", 4, 100);
    m_ready = 1'b0;
    wait_mvalid("t4_vec4_held", 40);
    abort = 1'b1;
    step();
    abort = 1'b0; feed_cnt = 0;
    chk("t4_idle",       128'(busy),       128'(0));
    chk("t4_m_valid",    128'(m_valid),    128'(0));
    chk("t4_layer_done", 128'(layer_done), 128'(0));
    chk("t4_s_ready",    128'(s_ready),    128'(0));
    repeat (10) step();
    chk("t4_no_ld_pulse", 128'(ld_cnt),    128'(0));
    chk("t4_beats",       128'(beat_cnt),  128'(3));
    chk("t4_still_idle",  128'(busy),      128'(0));
    m_ready = 1'b1;

    // Asynchronous reset in WAIT_DONE, then a fresh layer
    clr_logs(); feed_cnt = 7;
    start_layer(3, 7);
    wait_starts("t5_reach_vec2", 2, 100);
    step();
    chk("t5_pre_busy", 128'(busy),    128'(1));
    chk("t5_pre_addr", 128'(rq_addr), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy",     128'(busy),        128'(0));
    chk("t5_rst_rq_addr",  128'(rq_addr),     128'(0));
    chk("t5_rst_rq_acc",   128'(|rq_acc),     128'(0));
    chk("t5_rst_zp",       128'(rq_out_zp),   128'(0));
    chk("t5_rst_m_valid",  128'(m_valid),     128'(0));
    chk("t5_rst_m_data",   128'(m_data),      128'(0));
    chk("t5_rst_s_ready",  128'(s_ready),     128'(0));
    chk("t5_rst_rq_start", 128'(rq_start),    128'(0));
    chk("t5_rst_ld",       128'(layer_done),  128'(0));
    feed_cnt = 0;
    step();
    rst_n = 1'b1;
    step();
    clr_logs(); feed_cnt = 2;
    start_layer(3, 2);
    wait_idle("t5_idle_timeout", 100);
    chk("t5_starts",      128'(start_cnt),   128'(2));
    chk("t5_addr0",       128'(addr_log[0]), 128'(0));
    chk("t5_addr1",       128'(addr_log[1]), 128'(1));
    chk("t5_beats",       128'(beat_cnt),    128'(2));
    chk("t5_beat0_data",  128'(beat_log[0]), 128'(exp_data(0)));
    chk("t5_layer_done",  128'(ld_cnt),      128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/requant_seq_ctrl.md
REQUANT_SEQ_CTRL -- requirements
Module: requant_seq_ctrl

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning lanes per requantize vector.
REQ-002 The block SHALL have parameter AW, default 20, meaning M/exp table address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 32, meaning max cycles waited for rq_done.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port cfg_start  input  1  one-cycle pulse starting a layer.
REQ-007 The block SHALL have port cfg_num_groups  input  AW  count of M/exp entries (address wrap point).
REQ-008 The block SHALL have port cfg_num_vec  input  32  vectors in the layer.
REQ-009 The block SHALL have port cfg_out_zp  input  8  signed output zero-point.
REQ-010 The block SHALL have port abort  input  1  synchronous layer abort.
REQ-011 The block SHALL have ports s_valid  input  1, s_ready  output  1 and s_acc  input  LANES*32, forming the accumulator stream.
REQ-012 The block SHALL have ports rq_start  output  1, rq_addr  output  AW, rq_acc  output  LANES*32 and rq_out_zp  output  8, which drive the requantizer.
REQ-013 The block SHALL have ports rq_ready  input  1, rq_done  input  1 and rq_ofm  input  LANES*8, which carry requantizer status and result.
REQ-014 The block SHALL have ports m_valid  output  1, m_ready  input  1 and m_data  output  LANES*8, forming the output stream.
REQ-015 The block SHALL have ports busy  output  1, layer_done  output  1 (one-cycle pulse) and err_timeout  output  1 (sticky).

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_IN, ISSUE, WAIT_DONE and HOLD_OUT; busy SHALL be high in every state except IDLE.
REQ-017 In IDLE, on cfg_start with cfg_num_vec!=0 and cfg_num_groups!=0, the block SHALL latch the cfg values, clear vec_cnt, addr and err_timeout, then go to WAIT_IN.
REQ-018 In IDLE, on cfg_start with cfg_num_vec==0 or cfg_num_groups==0, the block SHALL pulse layer_done on the next cycle and stay in IDLE.
REQ-019 The block SHALL ignore cfg_start outside IDLE.
REQ-020 s_ready SHALL equal (state==WAIT_IN) & rq_ready; on an s_valid&s_ready beat the block SHALL register s_acc into rq_acc and go to ISSUE.
REQ-021 ISSUE SHALL last exactly one cycle with rq_start=1 (Moore output), then go to WAIT_DONE; rq_start SHALL be 0 in every other state.
REQ-022 rq_addr, rq_acc and rq_out_zp SHALL be registered and stable from ISSUE through WAIT_DONE.
REQ-023 In WAIT_DONE, on rq_done the block SHALL register rq_ofm into m_data, set m_valid and go to HOLD_OUT; rq_done in any other state SHALL be ignored.
REQ-024 The WAIT_DONE timer SHALL clear on entry; when it reaches TIMEOUT without rq_done, the block SHALL set err_timeout, drop the vector (no output beat) and advance as in REQ-026.
REQ-025 In HOLD_OUT, m_valid and m_data SHALL stay stable until m_ready; no new input SHALL be accepted meanwhile.
REQ-026 On an m_valid&m_ready beat (or on a timeout), vec_cnt SHALL increment, and addr SHALL become 0 if addr+1==cfg_num_groups, else addr+1.
REQ-027 If the new vec_cnt equals cfg_num_vec, the block SHALL go to IDLE and pulse layer_done for one cycle; otherwise it SHALL go to WAIT_IN.
REQ-028 When abort is high in any state, the block SHALL go to IDLE on the next edge, clear m_valid, and SHALL NOT pulse layer_done; abort has priority over every other event.
REQ-029 Throughput SHALL be at most one vector per (requantizer latency + 3) cycles; the block SHALL NOT overlap vectors.

Reset
REQ-030 When rst_n is low, at any time, the block SHALL immediately force state=IDLE and clear all outputs, counters, addr and err_timeout to 0.
REQ-031 After rst_n deasserts, the block SHALL need only a cfg_start to begin a layer.

Verification
REQ-032 The bench SHALL apply groups=3, vec=7, model done latency 4 and SHALL check rq_addr sequence 0,1,2,0,1,2,0, seven m beats in order and one layer_done pulse after beat 7.
REQ-033 The bench SHALL hold m_ready low for 10 cycles in HOLD_OUT and SHALL check that m_data is stable, m_valid=1, s_ready=0 and no rq_start occurs.
REQ-034 The bench SHALL withhold rq_done for vector 2 of 7 and SHALL check err_timeout=1 after 32 cycles, 6 output beats, layer_done still pulsed and addr advanced.
REQ-035 The bench SHALL apply cfg_start with vec=0 and SHALL check layer_done one cycle later, with busy and rq_start never asserting.
REQ-036 The bench SHALL assert rst_n low mid-WAIT_DONE and SHALL check all outputs are 0 at once; a following layer SHALL start at rq_addr=0.
REQ-037 The bench SHALL pulse abort during vector 4 and SHALL check IDLE next cycle, m_valid=0 and no layer_done pulse.
